// File: rtl/display_scheduler.sv
// display_scheduler
//   Arbitrates the 4-digit LED display between the local calculator/keyboard
//   path and a byte received over UART from the remote peer. A received byte
//   is converted to BCD with a sequential double-dabble (one shift per cycle).
//   The result is shown for HOLD_CYCLES cycles, and then the display returns
//   to the local path.
//
// Ports
//   clk                 system clock
//   reset               asynchronous, active-high reset
//   loc_n               local digit-enable mask (bit3 = num1 ... bit0 = num4)
//   loc_num1..loc_num4  local BCD digits, num1 leftmost
//   loc_activity        one-cycle pulse on any local key event
//   rx_data             received byte, unsigned binary
//   rx_ready            one-cycle pulse, rx_data valid this cycle
//   n                   digit-enable mask to the display (registered)
//   num1..num4          BCD digits to the display (registered)
//   src                 0 = local shown, 1 = remote shown
//   conv_busy           high while the BCD conversion runs
module display_scheduler #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] loc_n,
  input  logic [3:0] loc_num1,
  input  logic [3:0] loc_num2,
  input  logic [3:0] loc_num3,
  input  logic [3:0] loc_num4,
  input  logic       loc_activity,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [3:0] n,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic       src,
  output logic       conv_busy
);

  localparam logic [1:0] ST_LOCAL  = 2'd0;
  localparam logic [1:0] ST_CONV   = 2'd1;
  localparam logic [1:0] ST_REMOTE = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  // One double-dabble step on {hundreds, tens, ones, binary}: correct every
  // BCD nibble that would overflow on doubling, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  // Leading-zero blanking. num1 is never lit for a remote byte.
  function automatic logic [3:0] blank_mask(input logic [3:0] hund,
                                            input logic [3:0] tens);
    if (hund != 4'd0)      return 4'b0111;
    else if (tens != 4'd0) return 4'b0011;
    else                   return 4'b0001;
  endfunction

  logic [1:0]       r_state;
  logic [19:0]      r_shift;
  logic [2:0]       r_step;
  logic [CNT_W-1:0] r_hold;
  logic [3:0]       r_n, r_num1, r_num2, r_num3, r_num4;
  logic             r_src, r_busy;

  logic [19:0]      w_shift_next;

  assign w_shift_next = dabble_step(r_shift);

  assign n         = r_n;
  assign num1      = r_num1;
  assign num2      = r_num2;
  assign num3      = r_num3;
  assign num4      = r_num4;
  assign src       = r_src;
  assign conv_busy = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOCAL;
      r_shift <= '0;
      r_step  <= '0;
      r_hold  <= '0;
      r_n     <= '0;
      r_num1  <= '0;
      r_num2  <= '0;
      r_num3  <= '0;
      r_num4  <= '0;
      r_src   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOCAL: begin
          if (rx_ready) begin
            // Display keeps its last local values while converting.
            r_shift <= {12'd0, rx_data};
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CONV;
          end else begin
            r_n    <= loc_n;
            r_num1 <= loc_num1;
            r_num2 <= loc_num2;
            r_num3 <= loc_num3;
            r_num4 <= loc_num4;
            r_src  <= 1'b0;
          end
        end

        ST_CONV: begin
          if (rx_ready) begin
            // Last byte wins: restart from step 1 on the new value.
            r_shift <= {12'd0, rx_data};
            r_step  <= '0;
          end else begin
            r_shift <= w_shift_next;
            r_step  <= r_step + 3'd1;
            if (r_step == 3'd7) begin
              r_num1  <= 4'd0;
              r_num2  <= w_shift_next[19:16];
              r_num3  <= w_shift_next[15:12];
              r_num4  <= w_shift_next[11:8];
              r_n     <= blank_mask(w_shift_next[19:16], w_shift_next[15:12]);
              r_src   <= 1'b1;
              r_busy  <= 1'b0;
              r_hold  <= '0;
              r_state <= ST_REMOTE;
            end
          end
        end

        ST_REMOTE: begin
          if (rx_ready) begin
            // Remote digits stay visible while the new byte converts.
            r_shift <= {12'd0, rx_data};
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_hold  <= '0;
            r_state <= ST_CONV;
          end else if (loc_activity || (r_hold == HOLD_LAST)) begin
            r_n     <= loc_n;
            r_num1  <= loc_num1;
            r_num2  <= loc_num2;
            r_num3  <= loc_num3;
            r_num4  <= loc_num4;
            r_src   <= 1'b0;
            r_state <= ST_LOCAL;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end

        default: r_state <= ST_LOCAL;
      endcase
    end
  end

endmodule
